pipe_stall_ctrl: RTL

- Central stall/flush sequencer for the 5-stage pipelined CPU.
- Drives clock-enable (CE) and synchronous-flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves load-use hazards, taken-branch redirects, instruction/data memory wait states and multi-cycle MDU ops, with a fixed priority.
- Also keeps saturating stall and flush performance counters.

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/sat_counter.sv | 26 ++
 rtl/pipe_stall_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM encodings,
// NOP encoding, default counter width and the load-use hazard helper.
package pipe_pkg;

    localparam int          CNT_W_DEF = 32;
    localparam logic [31:0] NOP_INSN  = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_IMEM_WAIT = 3'd1,
        ST_DMEM_WAIT = 3'd2,
        ST_MDU_BUSY  = 3'd3
    } state_t;

    // A load into x0 can never produce a value the ID stage depends on.
    function automatic logic load_use(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic       rs1_use,
        input logic [4:0] rs1,
        input logic       rs2_use,
        input logic [4:0] rs2
    );
        return mem_read && (rd != 5'd0) &&
               ((rs1_use && (rs1 == rd)) || (rs2_use && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_r;

    // Count enabled events, holding at all-ones once reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {W{1'b0}};
        end else if (inc && (cnt_r != {W{1'b1}})) begin
            cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer: Mealy CE/flush controls for the PC and the
// four pipeline registers, plus saturating stall and flush counters.
module pipe_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int MDU_LAT = 8,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_rs1_use,
    input  logic             id_rs2_use,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             ex_mdu_op,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_ce,
    output logic             ifid_ce,
    output logic             idex_ce,
    output logic             exmem_ce,
    output logic             memwb_ce,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int MW = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;

    state_t        state_r, state_nx_s;
    logic [MW-1:0] mdu_cnt_r;
    logic          mdu_ld_s, mdu_dec_s, flush_ev_s, lu_s;
    logic          pc_ce_s, ifid_ce_s, idex_ce_s, exmem_ce_s, memwb_ce_s;
    logic          ifid_flush_s, idex_flush_s, exmem_flush_s;

    assign lu_s = load_use(ex_mem_read, ex_rd, id_rs1_use, id_rs1, id_rs2_use, id_rs2);

    // Priority resolution of hazards into CE/flush controls and next state.
    always_comb begin
        pc_ce_s       = 1'b1;
        ifid_ce_s     = 1'b1;
        idex_ce_s     = 1'b1;
        exmem_ce_s    = 1'b1;
        memwb_ce_s    = 1'b1;
        ifid_flush_s  = 1'b0;
        idex_flush_s  = 1'b0;
        exmem_flush_s = 1'b0;
        state_nx_s    = state_r;
        mdu_ld_s      = 1'b0;
        mdu_dec_s     = 1'b0;
        flush_ev_s    = 1'b0;
        if (rst) begin
            pc_ce_s    = 1'b0;
            ifid_ce_s  = 1'b0;
            idex_ce_s  = 1'b0;
            exmem_ce_s = 1'b0;
            memwb_ce_s = 1'b0;
            state_nx_s = ST_RUN;
        end else begin
            case (state_r)
                ST_RUN, ST_IMEM_WAIT: begin
                    if (dmem_req && !dmem_ready) begin
                        pc_ce_s    = 1'b0;
                        ifid_ce_s  = 1'b0;
                        idex_ce_s  = 1'b0;
                        exmem_ce_s = 1'b0;
                        memwb_ce_s = 1'b0;
                        state_nx_s = ST_DMEM_WAIT;
                    end else if (ex_mdu_op) begin
                        pc_ce_s       = 1'b0;
                        ifid_ce_s     = 1'b0;
                        idex_ce_s     = 1'b0;
                        exmem_ce_s    = 1'b0;
                        exmem_flush_s = 1'b1;
                        mdu_ld_s      = 1'b1;
                        state_nx_s    = ST_MDU_BUSY;
                    end else if (ex_branch_taken) begin
                        ifid_flush_s = 1'b1;
                        idex_flush_s = 1'b1;
                        flush_ev_s   = 1'b1;
                        state_nx_s   = ST_RUN;
                    end else if (lu_s) begin
                        pc_ce_s      = 1'b0;
                        ifid_ce_s    = 1'b0;
                        idex_flush_s = 1'b1;
                        state_nx_s   = ST_RUN;
                    end else if (!imem_ready) begin
                        pc_ce_s      = 1'b0;
                        ifid_flush_s = 1'b1;
                        state_nx_s   = ST_IMEM_WAIT;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end
                ST_DMEM_WAIT: begin
                    if (!dmem_ready) begin
                        pc_ce_s    = 1'b0;
                        ifid_ce_s  = 1'b0;
                        idex_ce_s  = 1'b0;
                        exmem_ce_s = 1'b0;
                        memwb_ce_s = 1'b0;
                        state_nx_s = ST_DMEM_WAIT;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end
                ST_MDU_BUSY: begin
                    // Entry cycle plus MDU_LAT-2 busy cycles keep the op in EX;
                    // the release cycle completes its MDU_LAT-cycle occupancy.
                    if (mdu_cnt_r != {MW{1'b0}}) begin
                        pc_ce_s       = 1'b0;
                        ifid_ce_s     = 1'b0;
                        idex_ce_s     = 1'b0;
                        exmem_ce_s    = 1'b0;
                        exmem_flush_s = 1'b1;
                        mdu_dec_s     = 1'b1;
                        state_nx_s    = ST_MDU_BUSY;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end
                default: begin
                    state_nx_s = ST_RUN;
                end
            endcase
        end
    end

    // FSM state and MDU occupancy counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_RUN;
            mdu_cnt_r <= {MW{1'b0}};
        end else begin
            state_r <= state_nx_s;
            if (mdu_ld_s) begin
                mdu_cnt_r <= MW'(MDU_LAT - 2);
            end else if (mdu_dec_s) begin
                mdu_cnt_r <= mdu_cnt_r - MW'(1);
            end else begin
                mdu_cnt_r <= mdu_cnt_r;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (!pc_ce_s && !rst),
        .cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_ev_s),
        .cnt (flush_cnt)
    );

    assign pc_ce       = pc_ce_s;
    assign ifid_ce     = ifid_ce_s;
    assign idex_ce     = idex_ce_s;
    assign exmem_ce    = exmem_ce_s;
    assign memwb_ce    = memwb_ce_s;
    assign ifid_flush  = ifid_flush_s;
    assign idex_flush  = idex_flush_s;
    assign exmem_flush = exmem_flush_s;
    assign state       = state_r;

endmodule
